// File: rtl/fir_pkg.sv
// Shared types, widths and the tap-length rule for the FIR sequencing controller.
package fir_pkg;

  localparam int unsigned SLOT_W    = 16;
  localparam int unsigned NUM_SLOTS = 15;
  localparam int unsigned TAP_W     = 4;
  localparam int unsigned FLAT_W    = SLOT_W * NUM_SLOTS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Odd tap count for a tap setting: 0 for 0, otherwise 2*floor(t/2)+1.
  function automatic logic [TAP_W-1:0] tap_len(input logic [TAP_W-1:0] t);
    return (t == '0) ? '0 : (t | TAP_W'(1));
  endfunction

endpackage

// File: rtl/fir_seq_ctrl_if.sv
// Sample-in / result-out handshake bundle for the FIR sequencing controller.
interface fir_seq_ctrl_if;
  import fir_pkg::*;

  logic              s_valid;
  logic [SLOT_W-1:0] s_data;
  logic              s_ready;
  logic              m_valid;
  logic [SLOT_W-1:0] m_data;
  logic              m_ready;

  // slave: the controller side; master: upstream source / downstream sink side
  modport slave  (input  s_valid, s_data, m_ready, output s_ready, m_valid, m_data);
  modport master (output s_valid, s_data, m_ready, input  s_ready, m_valid, m_data);

endinterface

// File: rtl/fir_delay_line.sv
// 15-slot sample history: slot 0 takes the new sample, the oldest slot falls off.
module fir_delay_line
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              i_clr,
  input  logic              i_shift,
  input  logic [SLOT_W-1:0] i_din,
  output logic [FLAT_W-1:0] o_data
);

  logic [NUM_SLOTS-1:0][SLOT_W-1:0] r_slots;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_slots <= '0;
    end else if (i_shift) begin
      r_slots <= {r_slots[NUM_SLOTS-2:0], i_din};
    end
  end

  assign o_data = r_slots;

endmodule

// File: rtl/fir_seq_ctrl.sv
// FIR sample sequencer: accepts samples, feeds the delay line, returns filter results.
// Optional build macro FIR_SEQ_PRIME_EN suppresses results until the delay line is primed.
module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter logic [TAP_W-1:0] RESET_TAP = TAP_W'(15)
) (
  input  logic              clk,
  input  logic              rst,
  fir_seq_ctrl_if.slave     bus,
  input  logic              cfg_load,
  input  logic [TAP_W-1:0]  cfg_tap,
  output logic [TAP_W-1:0]  flt_tap,
  output logic [FLAT_W-1:0] flt_data,
  input  logic [SLOT_W-1:0] flt_result,
  output logic              primed
);

  state_t           r_state;
  logic [TAP_W-1:0] r_tap;
  logic [TAP_W-1:0] r_fill;
  logic             r_m_valid;
  logic             r_primed;

  logic             w_s_ready;
  logic             w_accept;
  logic             w_clr;
  logic             w_out_en;
  logic [TAP_W-1:0] w_fill_inc;

  // A config load owns the IDLE cycle, so no sample is taken alongside it.
  assign w_s_ready  = !rst && (r_state == IDLE) && !cfg_load;
  assign w_accept   = w_s_ready && bus.s_valid;
  assign w_clr      = rst || ((r_state == IDLE) && cfg_load);
  assign w_fill_inc = (r_fill < tap_len(r_tap)) ? (r_fill + TAP_W'(1)) : r_fill;

`ifdef FIR_SEQ_PRIME_EN
  assign w_out_en = (r_fill >= tap_len(r_tap));
`else
  assign w_out_en = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_tap     <= RESET_TAP;
      r_fill    <= '0;
      r_m_valid <= 1'b0;
      r_primed  <= (RESET_TAP == '0);
    end else begin
      case (r_state)
        IDLE: begin
          if (cfg_load) begin
            r_tap    <= cfg_tap;
            r_fill   <= '0;
            r_primed <= (cfg_tap == '0);
          end else if (bus.s_valid) begin
            r_fill   <= w_fill_inc;
            r_primed <= (w_fill_inc >= tap_len(r_tap));
            r_state  <= WAIT;
          end
        end
        // Filter registers its result during this cycle.
        WAIT: begin
          if (w_out_en) begin
            r_state   <= OUT;
            r_m_valid <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        OUT: begin
          if (bus.m_ready) begin
            r_state   <= IDLE;
            r_m_valid <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_m_valid <= 1'b0;
        end
      endcase
    end
  end

  fir_delay_line u_delay_line (
    .clk     (clk),
    .i_clr   (w_clr),
    .i_shift (w_accept),
    .i_din   (bus.s_data),
    .o_data  (flt_data)
  );

  // Delay line and tap are frozen in OUT, so the filter result holds steady.
  assign bus.s_ready = w_s_ready;
  assign bus.m_valid = r_m_valid;
  assign bus.m_data  = r_m_valid ? flt_result : '0;
  assign flt_tap     = r_tap;
  assign primed      = r_primed;

endmodule
